// File: rtl/sm83_irq_ctrl_if.sv
// ----------------------------------------------------------------------------
// sm83_irq_ctrl_if
//
// Purpose: groups the CPU-side signals of the SM83 interrupt controller: the
// memory-mapped register bus (IF at 0xFF0F, IE at 0xFFFF) and the interrupt
// dispatch handshake.
//
// Handshake (valid/ready): the CPU raises ack_req as a level and holds it until
// it has seen ack_vld. The controller answers with exactly one single-cycle
// ack_vld pulse per request, with irq_vec valid in that cycle and held until
// the next dispatch. The CPU must drop ack_req before a new request is accepted.
//
// Signals:
//   addr        CPU bus address
//   wdata       CPU write data
//   wr, rd      one-cycle write / read strobes
//   rdata       registered read data
//   rd_hit      registered; rdata valid this cycle
//   irq_pending |(IE & IF), combinational
//   ack_req     dispatch request level from the CPU
//   ack_vld     one-cycle dispatch acknowledge
//   irq_vec     dispatch vector (8'h00 for a cancelled dispatch)
//
// Modports: master = CPU side, slave = interrupt controller side.
// ----------------------------------------------------------------------------
interface sm83_irq_ctrl_if;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        wr;
    logic        rd;
    logic [7:0]  rdata;
    logic        rd_hit;
    logic        irq_pending;
    logic        ack_req;
    logic        ack_vld;
    logic [7:0]  irq_vec;

    modport master (
        output addr, wdata, wr, rd, ack_req,
        input  rdata, rd_hit, irq_pending, ack_vld, irq_vec
    );

    modport slave (
        input  addr, wdata, wr, rd, ack_req,
        output rdata, rd_hit, irq_pending, ack_vld, irq_vec
    );
endinterface

// File: rtl/sm83_irq_ctrl.sv
// ----------------------------------------------------------------------------
// sm83_irq_ctrl
//
// Purpose: bus-side interrupt controller for the SM83 core. Latches rising
// edges of the peripheral request lines into IF, reports pending-and-enabled
// requests, resolves priority (lowest bit wins) during the CPU dispatch
// handshake, returns the RST vector and clears the serviced IF bit. IME lives
// in the CPU and is not seen here.
//
// Ports:
//   clk        core clock
//   rst_n      asynchronous active-low reset
//   irq_src    level requests [0] VBlank [1] STAT [2] Timer [3] Serial [4] Joypad
//   bus        sm83_irq_ctrl_if.slave (register bus + dispatch handshake)
//   fsm_state  dispatch FSM state, for observation (0 IDLE, 1 GRANT, 2 HOLD)
// ----------------------------------------------------------------------------
module sm83_irq_ctrl (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           irq_src,
    sm83_irq_ctrl_if.slave       bus,
    output logic [1:0]           fsm_state
);

    localparam logic [15:0] IF_ADDR  = 16'hFF0F;
    localparam logic [15:0] IE_ADDR  = 16'hFFFF;
    localparam logic [7:0]  VEC_BASE = 8'h40;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state, state_next;

    logic [4:0]  if_q;
    logic [7:0]  ie_q;
    logic [4:0]  src_prev;
    logic [7:0]  rdata_q;
    logic        rd_hit_q;
    logic        ack_vld_q;
    logic [7:0]  irq_vec_q;

    logic [4:0]  set_vec;
    logic        wr_if, wr_ie, rd_if, rd_ie;
    logic [4:0]  pend;
    logic [2:0]  win_idx;
    logic [4:0]  clr_mask;
    logic [7:0]  grant_vec;
    logic        grant;
    logic [4:0]  if_next;

    assign set_vec = irq_src & ~src_prev;

    assign wr_if = bus.wr && (bus.addr == IF_ADDR);
    assign wr_ie = bus.wr && (bus.addr == IE_ADDR);
    assign rd_if = bus.rd && (bus.addr == IF_ADDR);
    assign rd_ie = bus.rd && (bus.addr == IE_ADDR);

    // Priority uses the registered (pre-write) IF and IE, so a same-cycle
    // write to IF cannot change which bit the grant clears.
    assign pend = if_q & ie_q[4:0];

    always_comb begin
        win_idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (pend[i]) win_idx = 3'(i);
        end
    end

    assign grant_vec = VEC_BASE + {2'b00, win_idx, 3'b000};

    // Dispatch FSM: next-state and grant decode.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        case (state)
            IDLE:    if (bus.ack_req) state_next = GRANT;
            GRANT: begin
                grant      = 1'b1;
                state_next = HOLD;
            end
            HOLD:    if (!bus.ack_req) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // An empty pending set at GRANT means IE/IF changed after the CPU saw
    // irq_pending: nothing is cleared and the vector is 8'h00.
    assign clr_mask = (grant && (pend != 5'd0)) ? (5'b00001 << win_idx) : 5'd0;

    // Write replaces, grant clears, then edges OR in last so a peripheral
    // edge always survives a colliding write or clear.
    assign if_next = ((wr_if ? bus.wdata[4:0] : if_q) & ~clr_mask) | set_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            if_q      <= 5'd0;
            ie_q      <= 8'd0;
            src_prev  <= 5'h1F;
            rdata_q   <= 8'h00;
            rd_hit_q  <= 1'b0;
            ack_vld_q <= 1'b0;
            irq_vec_q <= 8'h00;
        end else begin
            state    <= state_next;
            if_q     <= if_next;
            src_prev <= irq_src;
            if (wr_ie) ie_q <= bus.wdata;

            // Reads return the value before any same-cycle update.
            rd_hit_q <= rd_if || rd_ie;
            if (rd_if)      rdata_q <= {3'b111, if_q};
            else if (rd_ie) rdata_q <= ie_q;

            ack_vld_q <= grant;
            if (grant) irq_vec_q <= (pend != 5'd0) ? grant_vec : 8'h00;
        end
    end

    assign bus.rdata       = rdata_q;
    assign bus.rd_hit      = rd_hit_q;
    assign bus.irq_pending = |pend;
    assign bus.ack_vld     = ack_vld_q;
    assign bus.irq_vec     = irq_vec_q;
    assign fsm_state       = state;

endmodule

// File: tb/tb_sm83_irq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sm83_irq_ctrl
//
// Directed bench for sm83_irq_ctrl. Inputs change 1 time unit after a rising
// clock edge and outputs are sampled at the same point, so every observation
// reflects the registers updated by the preceding edge.
// ----------------------------------------------------------------------------
module tb_sm83_irq_ctrl;

    localparam logic [15:0] IF_ADDR = 16'hFF0F;
    localparam logic [15:0] IE_ADDR = 16'hFFFF;

    logic       clk;
    logic       rst_n;
    logic [4:0] irq_src;
    logic [1:0] fsm_state;

    int tests_run;
    int tests_failed;

    sm83_irq_ctrl_if bus ();

    sm83_irq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_src   (irq_src),
        .bus       (bus.slave),
        .fsm_state (fsm_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.wr    = 1'b1;
        tick();
        bus.wr    = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic hit);
        bus.addr = a;
        bus.rd   = 1'b1;
        tick();
        bus.rd   = 1'b0;
        d        = bus.rdata;
        hit      = bus.rd_hit;
    endtask

    // Full dispatch: raise ack_req, wait (bounded) for ack_vld, drop ack_req,
    // then one more cycle so HOLD returns to IDLE.
    task automatic do_ack(output logic [7:0] vec, output int lat);
        logic got;
        got = 1'b0;
        vec = 8'h00;
        lat = 0;
        bus.ack_req = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            lat++;
            if (bus.ack_vld) begin
                got = 1'b1;
                vec = bus.irq_vec;
            end
        end
        bus.ack_req = 1'b0;
        if (!got) check("ack_timeout", 16'd0, 16'd1);
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] rd_val;
        logic       hit;
        logic [7:0] vec;
        int         lat;
        int         pulses;

        tests_run    = 0;
        tests_failed = 0;
        bus.addr     = 16'h0000;
        bus.wdata    = 8'h00;
        bus.wr       = 1'b0;
        bus.rd       = 1'b0;
        bus.ack_req  = 1'b0;
        irq_src      = 5'h1F;
        rst_n        = 1'b0;

        // Reset state with all sources high.
        #1;
        check("rst_ack_vld", {15'd0, bus.ack_vld}, 16'd0);
        check("rst_irq_vec", {8'd0, bus.irq_vec}, 16'h00);
        check("rst_rdata", {8'd0, bus.rdata}, 16'h00);
        check("rst_rd_hit", {15'd0, bus.rd_hit}, 16'd0);
        check("rst_pending", {15'd0, bus.irq_pending}, 16'd0);
        check("rst_state", {14'd0, fsm_state}, 16'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        bus_read(IF_ADDR, rd_val, hit);
        check("if_after_rst_high_src", {8'd0, rd_val}, 16'hE0);
        check("rd_hit_if", {15'd0, hit}, 16'd1);
        check("pending_after_rst", {15'd0, bus.irq_pending}, 16'd0);

        // Edge on bit 2 latches.
        irq_src = 5'h00;
        tick();
        irq_src = 5'h04;
        tick();
        bus_read(IF_ADDR, rd_val, hit);
        check("if_edge_bit2", {8'd0, rd_val}, 16'hE4);
        check("pending_ie_zero", {15'd0, bus.irq_pending}, 16'd0);
        bus_write(IF_ADDR, 8'h00);

        // Priority dispatch: bits 0 and 2 pending, IE = 0x05.
        bus_write(IE_ADDR, 8'h05);
        irq_src = 5'h00;
        tick();
        irq_src = 5'h05;
        tick();
        irq_src = 5'h00;
        check("pending_two_bits", {15'd0, bus.irq_pending}, 16'd1);
        do_ack(vec, lat);
        check("ack1_latency", lat[15:0], 16'd2);
        check("ack1_vec", {8'd0, vec}, 16'h40);
        check("ack1_vld_dropped", {15'd0, bus.ack_vld}, 16'd0);
        check("ack1_pending_left", {15'd0, bus.irq_pending}, 16'd1);
        bus_read(IF_ADDR, rd_val, hit);
        check("ack1_if", {8'd0, rd_val}, 16'hE4);
        do_ack(vec, lat);
        check("ack2_vec", {8'd0, vec}, 16'h50);
        bus_read(IF_ADDR, rd_val, hit);
        check("ack2_if", {8'd0, rd_val}, 16'hE0);
        check("ack2_pending", {15'd0, bus.irq_pending}, 16'd0);

        // Cancelled dispatch: IE cleared in the cycle before GRANT.
        bus_write(IF_ADDR, 8'h01);
        bus_write(IE_ADDR, 8'h01);
        check("cancel_pending_pre", {15'd0, bus.irq_pending}, 16'd1);
        bus.addr    = IE_ADDR;
        bus.wdata   = 8'h00;
        bus.wr      = 1'b1;
        bus.ack_req = 1'b1;
        tick();
        bus.wr = 1'b0;
        check("cancel_grant_state", {14'd0, fsm_state}, 16'd1);
        tick();
        check("cancel_ack_vld", {15'd0, bus.ack_vld}, 16'd1);
        check("cancel_vec", {8'd0, bus.irq_vec}, 16'h00);
        bus.ack_req = 1'b0;
        tick();
        bus_read(IF_ADDR, rd_val, hit);
        check("cancel_if_kept", {8'd0, rd_val}, 16'hE1);
        bus_write(IF_ADDR, 8'h00);

        // Collision: IF write of 0 with a same-cycle edge on bit 3.
        bus.addr  = IF_ADDR;
        bus.wdata = 8'h00;
        bus.wr    = 1'b1;
        irq_src   = 5'h08;
        tick();
        bus.wr = 1'b0;
        bus_read(IF_ADDR, rd_val, hit);
        check("collide_write_edge", {8'd0, rd_val}, 16'hE8);

        // Collision: grant clear of bit 3 with a same-cycle edge on bit 3.
        bus_write(IE_ADDR, 8'h08);
        irq_src = 5'h00;
        tick();
        bus.ack_req = 1'b1;
        tick();
        irq_src = 5'h08;
        tick();
        check("collide_ack_vld", {15'd0, bus.ack_vld}, 16'd1);
        check("collide_vec", {8'd0, bus.irq_vec}, 16'h58);
        bus.ack_req = 1'b0;
        irq_src     = 5'h00;
        tick();
        bus_read(IF_ADDR, rd_val, hit);
        check("collide_clear_edge", {8'd0, rd_val}, 16'hE8);
        bus_write(IF_ADDR, 8'h00);

        // ack_req held 5 cycles: a single pulse and a single clear.
        bus_write(IF_ADDR, 8'h06);
        bus_write(IE_ADDR, 8'h06);
        pulses = 0;
        vec    = 8'h00;
        bus.ack_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.ack_vld) begin
                pulses++;
                vec = bus.irq_vec;
            end
        end
        bus.ack_req = 1'b0;
        tick();
        if (bus.ack_vld) pulses++;
        tick();
        check("hold_pulses", pulses[15:0], 16'd1);
        check("hold_vec", {8'd0, vec}, 16'h48);
        bus_read(IF_ADDR, rd_val, hit);
        check("hold_if_one_clear", {8'd0, rd_val}, 16'hE4);

        // Reset asserted during HOLD.
        bus_write(IF_ADDR, 8'h1C);
        bus.ack_req = 1'b1;
        tick();
        tick();
        check("rst_hold_vec_pre", {8'd0, bus.irq_vec}, 16'h50);
        tick();
        check("rst_hold_state_pre", {14'd0, fsm_state}, 16'd2);
        rst_n = 1'b0;
        #1;
        check("rst_hold_ack_vld", {15'd0, bus.ack_vld}, 16'd0);
        check("rst_hold_vec", {8'd0, bus.irq_vec}, 16'h00);
        check("rst_hold_pending", {15'd0, bus.irq_pending}, 16'd0);
        check("rst_hold_state", {14'd0, fsm_state}, 16'd0);
        bus.ack_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        bus_read(IF_ADDR, rd_val, hit);
        check("rst_hold_if", {8'd0, rd_val}, 16'hE0);
        bus_read(IE_ADDR, rd_val, hit);
        check("rst_hold_ie", {8'd0, rd_val}, 16'h00);

        // Bus decode.
        bus_write(IF_ADDR, 8'h03);
        bus_write(IE_ADDR, 8'h12);
        bus_write(16'hFF0E, 8'hFF);
        bus_write(16'hFFFE, 8'hFF);
        check("decode_no_hit_wr", {15'd0, bus.rd_hit}, 16'd0);
        bus_read(IE_ADDR, rd_val, hit);
        check("decode_ie_kept", {8'd0, rd_val}, 16'h12);
        bus_read(16'hFF0E, rd_val, hit);
        check("decode_miss_hit", {15'd0, hit}, 16'd0);
        check("decode_miss_rdata_held", {8'd0, rd_val}, 16'h12);
        bus_read(IF_ADDR, rd_val, hit);
        check("decode_if_kept", {8'd0, rd_val}, 16'hE3);
        bus_write(IE_ADDR, 8'hA5);
        bus_read(IE_ADDR, rd_val, hit);
        check("ie_readback", {8'd0, rd_val}, 16'hA5);
        check("ie_readback_hit", {15'd0, hit}, 16'd1);
        tick();
        check("rd_hit_one_cycle", {15'd0, bus.rd_hit}, 16'd0);

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
